ahb_blockram_if: RTL and testbench

AHB-Lite slave front end for the on-chip code/data block RAM of the Cortex-M0 subsystem. It sits directly upstream of the dual-port block RAM: it decodes AHB address and data phases into the RAM write port (addra/dina/wea) and read port (addrb/doutb). It generates byte-lane enables from HSIZE/HADDR and forwards a write into an immediately following read of the same word, so the bus sees zero-wait-state, coherent memory.

---
 rtl/ahb_blockram_if_if.sv | 23 ++
 rtl/ahb_blockram_if.sv | 65 ++++++
 tb/tb_ahb_blockram_if.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_blockram_if_if.sv
// ahb_blockram_if_if: AHB-Lite bus bundle between a bus master and the block RAM slave
//   master: drives HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY; receives HREADYOUT, HRESP, HRDATA
//   slave : the mirror image
interface ahb_blockram_if_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;
  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_blockram_if.sv
// ahb_blockram_if: zero-wait-state AHB-Lite slave driving a dual-port block RAM
//   clka/rsta : clock, asynchronous active-high reset
//   ahb       : AHB-Lite slave bus (HREADYOUT tied 1, HRESP tied OKAY)
//   addra/dina/wea : RAM write port, active during the write data phase
//   addrb/doutb    : RAM read port, doutb arrives one cycle after addrb
module ahb_blockram_if #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clka,
  input  logic                  rsta,
  ahb_blockram_if_if.slave      ahb,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [31:0]           dina,
  output logic [3:0]            wea,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [31:0]           doutb
);
  logic                  accept, wr_accept, hazard_d;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            mask_d;
  logic                  wr_pend_q, hz_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [3:0]            wr_mask_q, hz_mask_q;
  logic [31:0]           hz_data_q;
  logic                  unused;
  assign accept    = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
  assign wr_accept = accept & ahb.HWRITE;
  assign addr      = ahb.HADDR[ADDR_WIDTH+1:2];
  assign unused    = ^{ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};
  always_comb
    mask_d = ahb.HSIZE == 3'd0 ? 4'b0001 << ahb.HADDR[1:0] :
             ahb.HSIZE == 3'd1 ? (ahb.HADDR[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // A read of the word whose write data phase is happening now gets stale RAM data
  assign hazard_d = accept & ~ahb.HWRITE & wr_pend_q & (addr == wr_addr_q);
  always_ff @(posedge clka or posedge rsta)
    if (rsta) begin
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_mask_q <= '0;
      hz_q      <= 1'b0;
      hz_mask_q <= '0;
      hz_data_q <= '0;
    end else begin
      wr_pend_q <= wr_accept;
      if (wr_accept) begin
        wr_addr_q <= addr;
        wr_mask_q <= mask_d;
      end
      hz_q <= hazard_d;
      if (hazard_d) begin
        hz_mask_q <= wr_mask_q;
        hz_data_q <= ahb.HWDATA;
      end
    end
  // Gated by the async-reset pending flag so a reset kills an in-flight write at once
  assign wea   = wr_pend_q ? wr_mask_q : 4'b0000;
  assign addra = wr_addr_q;
  assign dina  = ahb.HWDATA;
  assign addrb = addr;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign ahb.HRDATA[8*i+:8] = hz_q & hz_mask_q[i] ? hz_data_q[8*i+:8] : doutb[8*i+:8];
  end
endmodule

// File: tb/tb_ahb_blockram_if.sv
// tb_ahb_blockram_if: directed bench with a byte-level memory model and per-cycle compare
module tb_ahb_blockram_if;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_chk = 1'b0;
  logic [13:0] addra, addrb;
  logic [31:0] dina, doutb;
  logic [3:0]  wea;
  bit   [31:0] ram  [0:16383];
  bit   [31:0] refm [0:16383];
  int          errs = 0;
  int          checks = 0;
  bit          m_wv = 0, m_rv = 0, m_pin_en = 0, next_pin_en = 0;
  logic [13:0] m_wa = '0;
  logic [3:0]  m_wm = '0;
  logic [31:0] m_rd = '0, m_pin = '0, next_pin = '0;

  ahb_blockram_if_if bus();

  ahb_blockram_if #(.ADDR_WIDTH(14)) dut (
    .clka(clk), .rsta(rst), .ahb(bus),
    .addra(addra), .dina(dina), .wea(wea), .addrb(addrb), .doutb(doutb)
  );

  always #5 clk = ~clk;

  // Block RAM: byte-enabled write port, registered read port returning old data on collision
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (wea[i]) ram[addra][8*i+:8] <= dina[8*i+:8];
    doutb <= ram[addrb];
  end

  // Lanes touched: a transfer of 2^size bytes (max 4) at the size-aligned offset in the word
  function automatic logic [3:0] mask_of(logic [2:0] sz, logic [1:0] a);
    int n, off;
    logic [3:0] m;
    n   = sz == 3'd0 ? 1 : sz == 3'd1 ? 2 : 4;
    off = int'(a) & ~(n - 1);
    m   = 4'((1 << n) - 1);
    return m << off;
  endfunction

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  always @(negedge clk or posedge rst_chk) begin
    chk("hreadyout", 32'(bus.HREADYOUT), 32'd1);
    chk("hresp", 32'(bus.HRESP), 32'd0);
    chk("wea", 32'(wea), 32'(rst ? 4'b0 : m_wv ? m_wm : 4'b0));
    chk("addrb", 32'(addrb), 32'(bus.HADDR[15:2]));
    if (rst) chk("addra_rst", 32'(addra), 32'd0);
    else if (m_wv) begin
      chk("addra", 32'(addra), 32'(m_wa));
      chk("dina", dina, bus.HWDATA);
    end
    if (!rst && m_rv) begin
      chk("hrdata", bus.HRDATA, m_rd);
      if (m_pin_en) begin
        chk("pin_model", m_rd, m_pin);
        chk("pin_hrdata", bus.HRDATA, m_pin);
      end
    end
  end

  // Advance one clock and update the model: the write in its data phase lands first,
  // then any read accepted at this edge sees the memory including that write.
  task automatic step();
    logic acc;
    logic [13:0] w;
    @(posedge clk);
    if (rst) begin
      m_wv = 0;
      m_rv = 0;
    end else begin
      if (m_wv)
        for (int i = 0; i < 4; i++)
          if (m_wm[i]) refm[m_wa][8*i+:8] = bus.HWDATA[8*i+:8];
      acc = bus.HSEL && bus.HTRANS[1] && bus.HREADY;
      w = bus.HADDR[15:2];
      m_rv = acc && !bus.HWRITE;
      m_rd = refm[w];
      m_pin_en = next_pin_en;
      m_pin = next_pin;
      m_wv = acc && bus.HWRITE;
      m_wa = w;
      m_wm = mask_of(bus.HSIZE, bus.HADDR[1:0]);
    end
    #1;
  endtask

  task automatic cyc(bit sel, bit [1:0] tr, bit w, bit [2:0] sz, logic [31:0] a,
                     logic [31:0] wd, bit rdy = 1);
    bus.HSEL = sel;
    bus.HTRANS = tr;
    bus.HWRITE = w;
    bus.HSIZE = sz;
    bus.HADDR = a;
    bus.HWDATA = wd;
    bus.HREADY = rdy;
    step();
  endtask

  task automatic wr(bit [2:0] sz, logic [31:0] a, logic [31:0] wd);
    cyc(1, 2'b10, 1, sz, a, wd);
  endtask

  task automatic rd(logic [31:0] a, logic [31:0] wd, bit pe, logic [31:0] pv);
    next_pin_en = pe;
    next_pin = pv;
    cyc(1, 2'b10, 0, 3'd2, a, wd);
    next_pin_en = 0;
  endtask

  task automatic idle(logic [31:0] wd);
    cyc(0, 2'b00, 0, 3'd0, 32'h0, wd);
  endtask

  initial begin
    idle(0);
    idle(0);
    rst = 0;
    idle(0);
    // word write then read
    wr(3'd2, 32'h10, 0);
    idle(32'hDEADBEEF);
    rd(32'h10, 0, 1, 32'hDEADBEEF);
    idle(0);
    // byte lanes
    wr(3'd0, 32'h20, 0);
    wr(3'd0, 32'h21, 32'h00000011);
    wr(3'd0, 32'h22, 32'h00002200);
    wr(3'd0, 32'h23, 32'h00330000);
    idle(32'h44000000);
    rd(32'h20, 0, 1, 32'h44332211);
    idle(0);
    // halfword over existing word (HADDR[0] ignored via 0x33 variant later)
    wr(3'd2, 32'h30, 0);
    idle(32'h44332211);
    wr(3'd1, 32'h32, 0);
    idle(32'hABCD0000);
    rd(32'h30, 0, 1, 32'hABCD2211);
    idle(0);
    wr(3'd1, 32'h33, 0);
    idle(32'h5A5A0000);
    rd(32'h30, 0, 1, 32'h5A5A2211);
    idle(0);
    // forwarding: read same word right after the write
    wr(3'd2, 32'h44, 0);
    idle(32'h0BADF00D);
    wr(3'd0, 32'h41, 0);
    rd(32'h40, 32'h00005500, 1, 32'h00005500);
    idle(0);
    // different word right after a write: no merge
    wr(3'd0, 32'h41, 0);
    rd(32'h44, 32'h00006600, 1, 32'h0BADF00D);
    idle(0);
    rd(32'h40, 0, 1, 32'h00006600);
    idle(0);
    // forwarding with a halfword mask over nonzero old data
    wr(3'd1, 32'h46, 0);
    rd(32'h44, 32'h1234FFFF, 1, 32'h1234F00D);
    idle(0);
    // continuous SEQ write stream, then read back
    wr(3'd2, 32'h100, 0);
    cyc(1, 2'b11, 1, 3'd2, 32'h104, 32'hA0A0A0A0);
    cyc(1, 2'b11, 1, 3'd2, 32'h108, 32'hB1B1B1B1);
    idle(32'hC2C2C2C2);
    rd(32'h100, 0, 1, 32'hA0A0A0A0);
    rd(32'h104, 0, 1, 32'hB1B1B1B1);
    rd(32'h108, 0, 1, 32'hC2C2C2C2);
    idle(0);
    // no-transfer variants
    cyc(1, 2'b00, 1, 3'd2, 32'h50, 0);
    idle(32'hFFFFFFFF);
    cyc(1, 2'b01, 1, 3'd2, 32'h50, 0);
    idle(32'hFFFFFFFF);
    cyc(0, 2'b10, 1, 3'd2, 32'h50, 0);
    idle(32'hFFFFFFFF);
    cyc(1, 2'b10, 1, 3'd2, 32'h50, 0, 0);
    idle(32'hFFFFFFFF);
    rd(32'h50, 0, 1, 32'h00000000);
    idle(0);
    // reset during a write data phase
    wr(3'd2, 32'h60, 0);
    bus.HSEL = 0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 0;
    bus.HWDATA = 32'h12345678;
    #2 rst = 1;
    #1 rst_chk = 1;
    step();
    step();
    rst = 0;
    rst_chk = 0;
    idle(0);
    rd(32'h60, 0, 1, 32'h00000000);
    idle(0);
    wr(3'd2, 32'h60, 0);
    rd(32'h60, 32'hCAFEF00D, 1, 32'hCAFEF00D);
    idle(0);
    rd(32'h60, 0, 1, 32'hCAFEF00D);
    idle(0);
    idle(0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
